// File: rtl/data_path_mc_if.sv
// rtl/data_path_mc_if.sv - request channels and FIFO read-side bus of data_path_mc
interface data_path_mc_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 16
);
  logic [N_CH-1:0]         ch_ce;
  logic [N_CH*ADDR_W-1:0]  ch_addr;
  logic [N_CH-1:0]         ch_ack;
  logic                    rd_en;
  logic [TAG_W+ADDR_W-1:0] dout;
  logic                    dout_valid;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  level;

  modport master (
    output ch_ce, ch_addr, rd_en,
    input  ch_ack, dout, dout_valid, full, empty, level
  );

  modport slave (
    input  ch_ce, ch_addr, rd_en,
    output ch_ack, dout, dout_valid, full, empty, level
  );
endinterface

// File: rtl/data_path_mc.sv
// rtl/data_path_mc.sv - N-channel arbiter feeding a tagged FIFO with registered read port
module data_path_mc #(
  parameter int N_CH     = 4,
  parameter int ADDR_W   = 8,
  parameter int TAG_W    = 4,
  parameter int DEPTH    = 16,
  parameter int ARB_MODE = 0
) (
  input logic           clk,
  input logic           rst,
  data_path_mc_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(N_CH);
  localparam int ENT_W = TAG_W + ADDR_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] rr_ptr, grant_idx, cand;
  logic [LVL_W-1:0] level_nxt;
  logic             found, wr_ok, wr_en, rd_acc;

  // First requester found scanning from rr_ptr (round-robin) or from 0 (fixed).
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ARB_MODE == 1) cand = IDX_W'(k);
      else               cand = IDX_W'((int'(rr_ptr) + k) % N_CH);
      if (!found && bus.ch_ce[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A read on a full FIFO frees the slot the same edge, so the write may proceed.
  assign rd_acc = bus.rd_en && !bus.empty;
  assign wr_ok  = !bus.full || bus.rd_en;
  assign wr_en  = !rst && wr_ok && found;

  always_comb begin
    bus.ch_ack = '0;
    if (wr_en) bus.ch_ack[grant_idx] = 1'b1;
  end

  assign level_nxt = bus.level + LVL_W'(wr_en) - LVL_W'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {TAG_W'(grant_idx), bus.ch_addr[int'(grant_idx)*ADDR_W +: ADDR_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rr_ptr         <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.level      <= '0;
      bus.full       <= 1'b0;
      bus.empty      <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (ARB_MODE == 0) rr_ptr <= IDX_W'((int'(grant_idx) + 1) % N_CH);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        bus.dout <= mem[rd_ptr];
      end
      bus.dout_valid <= rd_acc;
      bus.level      <= level_nxt;
      bus.full       <= (level_nxt == LVL_W'(DEPTH));
      bus.empty      <= (level_nxt == '0);
    end
  end
endmodule

// File: tb/tb_data_path_mc.sv
// tb/tb_data_path_mc.sv - scoreboard bench for round-robin and fixed-priority instances
module tb_data_path_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic [3:0]  ce   [2];
  logic [31:0] addr [2];

  data_path_mc_if #(.N_CH(4), .ADDR_W(8), .TAG_W(4), .DEPTH(16)) if0 ();
  data_path_mc_if #(.N_CH(4), .ADDR_W(8), .TAG_W(4), .DEPTH(16)) if1 ();

  assign if0.ch_ce = ce[0];  assign if0.ch_addr = addr[0];  assign if0.rd_en = rd;
  assign if1.ch_ce = ce[1];  assign if1.ch_addr = addr[1];  assign if1.rd_en = rd;

  data_path_mc #(.N_CH(4), .ADDR_W(8), .TAG_W(4), .DEPTH(16), .ARB_MODE(0))
    u_rr (.clk(clk), .rst(rst), .bus(if0));
  data_path_mc #(.N_CH(4), .ADDR_W(8), .TAG_W(4), .DEPTH(16), .ARB_MODE(1))
    u_fp (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  wire [7:0]  ack = {if1.ch_ack, if0.ch_ack};
  wire [1:0]  dv  = {if1.dout_valid, if0.dout_valid};
  wire [23:0] dq  = {if1.dout, if0.dout};
  wire [9:0]  lv  = {if1.level, if0.level};
  wire [1:0]  fl  = {if1.full, if0.full};
  wire [1:0]  em  = {if1.empty, if0.empty};

  int          checks = 0;
  int          errors = 0;
  logic [11:0] mq  [2][$];
  logic [11:0] exq [2][$];
  logic [11:0] mlast [2];
  int          rr;
  int          gsel [2];
  logic [3:0]  acked [2];
  logic [11:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(int d, logic [3:0] c, bit ok);
    if (!ok || c == 4'b0) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (d == 0) ? (rr + k) % 4 : k;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      exq[d].delete();
      mlast[d] = '0;
    end
    rr = 0;
  endtask

  task automatic step();
    logic [3:0]  eack;
    logic [11:0] e;
    bit          ok;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ok      = (mq[d].size() < 16) || rd;
      gsel[d] = rst ? -1 : model_grant(d, ce[d], ok);
      eack    = (gsel[d] < 0) ? 4'b0 : 4'(1 << gsel[d]);
      chk($sformatf("ack%0d", d), 32'(ack[d*4 +: 4]), 32'(eack));
      chk($sformatf("level%0d", d), 32'(lv[d*5 +: 5]), mq[d].size());
      chk($sformatf("full%0d", d), 32'(fl[d]), 32'(mq[d].size() == 16));
      chk($sformatf("empty%0d", d), 32'(em[d]), 32'(mq[d].size() == 0));
      chk($sformatf("dout_hold%0d", d), 32'(dq[d*12 +: 12]), 32'(mlast[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acked[d] = 4'b0;
      if (!rst) begin
        if (rd && mq[d].size() > 0) begin
          e = mq[d].pop_front();
          exq[d].push_back(e);
          mlast[d] = e;
        end
        if (gsel[d] >= 0) begin
          mq[d].push_back({4'(gsel[d]), addr[d][gsel[d]*8 +: 8]});
          acked[d][gsel[d]] = 1'b1;
          if (d == 0) rr = (gsel[d] + 1) % 4;
        end
      end
    end
    #1;
  endtask

  // Scoreboard monitor: every presented dout must match the oldest expected read.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (dv[d]) begin
          if (exq[d].size() == 0) chk($sformatf("spurious_valid%0d", d), 32'(1), 32'(0));
          else begin
            mon_e = exq[d].pop_front();
            chk($sformatf("dout%0d", d), 32'(dq[d*12 +: 12]), 32'(mon_e));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rd = 1'b0;
    ce[0] = 4'h0; ce[1] = 4'h0;
    addr[0] = 32'hddccbbaa; addr[1] = 32'hddccbbaa;
    acked[0] = 4'h0; acked[1] = 4'h0;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_level", 32'(lv[d*5 +: 5]), 32'd0);
      chk("rst_empty", 32'(em[d]), 32'd1);
      chk("rst_full", 32'(fl[d]), 32'd0);
      chk("rst_dout", 32'(dq[d*12 +: 12]), 32'd0);
      chk("rst_dv", 32'(dv[d]), 32'd0);
    end
    ce[0] = 4'hf; ce[1] = 4'hf;
    step(); step();
    rst = 1'b0;

    // Fill with all channels requesting, then full blocks grants.
    repeat (16) step();
    chk("fill_full0", 32'(fl[0]), 32'd1);
    chk("fill_level0", 32'(lv[4:0]), 32'd16);
    repeat (3) step();

    // Streaming read while full: level holds, order and tags checked by scoreboard.
    rd = 1'b1;
    repeat (12) step();
    chk("stream_level0", 32'(lv[4:0]), 32'd16);

    ce[0] = 4'h0; ce[1] = 4'h0;
    repeat (20) step();
    repeat (3) step();
    rd = 1'b0;

    // Single request on channel 2, read it back.
    ce[0] = 4'b0100; ce[1] = 4'b0100;
    step();
    ce[0] = 4'h0; ce[1] = 4'h0; rd = 1'b1;
    step();
    rd = 1'b0;
    step(); step();

    // Randomized traffic; requests are held until their own instance acknowledges them.
    repeat (300) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (ce[d][i] && acked[d][i]) ce[d][i] = ($urandom_range(0, 1) == 1);
          if (!ce[d][i] && $urandom_range(0, 2) == 0) begin
            ce[d][i] = 1'b1;
            addr[d][i*8 +: 8] = 8'($urandom);
          end
        end
      end
      rd = ($urandom_range(0, 2) != 0);
      step();
    end

    ce[0] = 4'h0; ce[1] = 4'h0; rd = 1'b1;
    repeat (20) step();
    rd = 1'b0;
    addr[0] = 32'hddccbbaa; addr[1] = 32'hddccbbaa;

    // Reset asserted mid-cycle at level 9.
    ce[0] = 4'hf; ce[1] = 4'hf;
    repeat (9) step();
    ce[0] = 4'h0; ce[1] = 4'h0;
    chk("pre_rst_level0", 32'(lv[4:0]), 32'd9);
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_level", 32'(lv[d*5 +: 5]), 32'd0);
      chk("async_full", 32'(fl[d]), 32'd0);
      chk("async_dv", 32'(dv[d]), 32'd0);
    end
    model_clear();
    step();
    rst = 1'b0;
    ce[0] = 4'hf; ce[1] = 4'hf;
    #2 chk("post_rst_grant0", 32'(ack[3:0]), 32'h1);
    step();
    ce[0] = 4'h0; ce[1] = 4'h0;
    repeat (3) step();

    for (int d = 0; d < 2; d++) chk($sformatf("pending_reads%0d", d), exq[d].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
